out_port_lock_ctrl: RTL and testbench

- Per-output-port wormhole allocator for the router crossbar.
- Selects one input port per packet using least-recently-granted priority, with multicast taking precedence over unicast.
- Holds the grant from head flit to tail flit.
- Meters flit forwarding against a downstream credit counter.
- One instance sits in front of each crossbar output mux and drives its select.

---
 rtl/out_port_lock_ctrl_if.sv | 30 +++
 rtl/out_port_lock_ctrl.sv | 143 ++++++++++++++
 tb/tb_out_port_lock_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/out_port_lock_ctrl_if.sv
// Handshake bundle between the router input side and one output-port lock controller.
// The master drives requests, flits and credits; the slave returns the lock state.
interface out_port_lock_ctrl_if #(
    parameter int PORT  = 4,
    parameter int PORTW = 2,
    parameter int CW    = 3
);
    logic [PORT:0]  u_req;
    logic [PORT:0]  m_req;
    logic [PORT:0]  multab_ct;
    logic [PORT:0]  flit_vld;
    logic [PORT:0]  flit_tail;
    logic           credit_in;
    logic [PORT:0]  grt;
    logic [PORTW:0] sel;
    logic           flit_send;
    logic           busy;
    logic [CW-1:0]  credit_cnt;
    logic           credit_err;

    modport master (
        output u_req, m_req, multab_ct, flit_vld, flit_tail, credit_in,
        input  grt, sel, flit_send, busy, credit_cnt, credit_err
    );

    modport slave (
        input  u_req, m_req, multab_ct, flit_vld, flit_tail, credit_in,
        output grt, sel, flit_send, busy, credit_cnt, credit_err
    );
endinterface

// File: rtl/out_port_lock_ctrl.sv
// Wormhole lock for one crossbar output: least-recently-granted arbitration with
// multicast precedence, head-to-tail grant hold and downstream credit metering.
module out_port_lock_ctrl #(
    parameter int PORT    = 4,
    parameter int PORTW   = 2,
    parameter int CREDITS = 4,
    parameter int CW      = 3
) (
    input logic                clk,
    input logic                rst_,
    out_port_lock_ctrl_if.slave bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    typedef logic [PORTW:0] port_id_t;

    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [CW-1:0] CRED_ONE = CW'(1);

    state_t         state_q, state_d;
    logic [PORT:0]  grt_q, grt_d;
    port_id_t       sel_q, sel_d;
    port_id_t       prio_q [PORT+1];
    port_id_t       prio_d [PORT+1];
    port_id_t       prio_rot [PORT+1];
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d;

    logic [PORT:0]  me;
    logic [PORT:0]  elig;
    logic           found;
    port_id_t       winner;
    logic           send;
    logic           release_lock;

    // Power-up ranking, highest first: PORT, PORT-1, then 0 upwards.
    function automatic port_id_t reset_rank(input int i);
        if (i == 0)      return port_id_t'(PORT);
        else if (i == 1) return port_id_t'(PORT - 1);
        else             return port_id_t'(i - 2);
    endfunction

    // Unmasked multicast requests shut unicast out entirely.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        me     = bus.m_req & ~bus.multab_ct;
        elig   = (me != '0) ? me : bus.u_req;
        found  = 1'b0;
        winner = '0;
        // Walk lowest to highest rank so the highest-ranked eligible input wins.
        for (int i = PORT; i >= 0; i--) begin
            if (elig[prio_q[i]]) begin
                found  = 1'b1;
                winner = prio_q[i];
            end
        end
    end

    assign send         = (state_q == LOCKED) && bus.flit_vld[sel_q] && (cnt_q != '0);
    assign release_lock = send && bus.flit_tail[sel_q];

    // Owner drops to the bottom; everything ranked below it shifts up one place.
    always_comb begin
        logic passed;
        passed = 1'b0;
        for (int i = 0; i < PORT; i++) begin
            if (prio_q[i] == sel_q) passed = 1'b1;
            prio_rot[i] = passed ? prio_q[i+1] : prio_q[i];
        end
        prio_rot[PORT] = sel_q;
    end

    always_comb begin
        state_d = state_q;
        grt_d   = grt_q;
        sel_d   = sel_q;
        prio_d  = prio_q;
        unique case (state_q)
            IDLE: begin
                grt_d = '0;
                if (found) begin
                    state_d       = LOCKED;
                    grt_d[winner] = 1'b1;
                    sel_d         = winner;
                end
            end
            LOCKED: begin
                if (release_lock) begin
                    state_d = IDLE;
                    grt_d   = '0;
                    prio_d  = prio_rot;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A return with the counter already full is a downstream protocol error.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        unique case ({send, bus.credit_in})
            2'b10: cnt_d = cnt_q - CRED_ONE;
            2'b01: begin
                if (cnt_q == CRED_MAX) err_d = 1'b1;
                else                   cnt_d = cnt_q + CRED_ONE;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q <= IDLE;
            grt_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= CRED_MAX;
            err_q   <= 1'b0;
            // NOTE: the priority list is control state, not storage, so it is reset like any flop.
            for (int i = 0; i <= PORT; i++) prio_q[i] <= reset_rank(i);
        end else begin
            state_q <= state_d;
            grt_q   <= grt_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            prio_q  <= prio_d;
        end
    end

    assign bus.grt        = grt_q;
    assign bus.sel        = sel_q;
    assign bus.busy       = (state_q == LOCKED);
    assign bus.flit_send  = send;
    assign bus.credit_cnt = cnt_q;
    assign bus.credit_err = err_q;

endmodule

// File: tb/tb_out_port_lock_ctrl.sv
// Directed bench for out_port_lock_ctrl: expected grant owners are queued as requests
// are driven and popped when the lock is observed; credits checked against fixed values.
module tb_out_port_lock_ctrl;
    localparam int PORT    = 4;
    localparam int PORTW   = 2;
    localparam int CREDITS = 4;
    localparam int CW      = 3;

    logic clk;
    logic rst_;
    int   checks = 0;
    int   errors = 0;
    int   sb[$];
    int   lru_order[6] = '{4, 3, 0, 1, 2, 4};
    logic wv[5]        = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int   sends;

    out_port_lock_ctrl_if #(.PORT(PORT), .PORTW(PORTW), .CW(CW)) bus ();

    out_port_lock_ctrl #(
        .PORT(PORT), .PORTW(PORTW), .CREDITS(CREDITS), .CW(CW)
    ) dut (
        .clk (clk),
        .rst_(rst_),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.u_req     = '0;
        bus.m_req     = '0;
        bus.multab_ct = '0;
        bus.flit_vld  = '0;
        bus.flit_tail = '0;
        bus.credit_in = 1'b0;
    endtask

    // Bounded wait for the lock, then compare against the next queued owner.
    task automatic expect_grant(input string tag);
        int n;
        int idx;
        logic [PORT:0] oh;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.busy !== 1'b1 && n < 20);
        check({tag, "_busy"}, bus.busy, 1);
        check({tag, "_latency"}, n, 1);
        idx = (sb.size() > 0) ? sb.pop_front() : -1;
        oh = '0;
        if (idx >= 0) oh[idx] = 1'b1;
        check({tag, "_grt"}, bus.grt, oh);
        check({tag, "_sel"}, bus.sel, idx);
    endtask

    initial begin
        clear_inputs();
        rst_ = 1'b0;
        tick();
        tick();
        check("rst_grt", bus.grt, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_sel", bus.sel, 0);
        check("rst_cnt", bus.credit_cnt, CREDITS);
        check("rst_err", bus.credit_err, 0);
        rst_ = 1'b1;

        // Least-recently-granted rotation with single-flit packets
        bus.u_req     = '1;
        bus.flit_vld  = '1;
        bus.flit_tail = '1;
        foreach (lru_order[k]) sb.push_back(lru_order[k]);
        for (int k = 0; k < 6; k++) begin
            expect_grant($sformatf("lru%0d", k));
            bus.credit_in = 1'b1;
            sample();
            check($sformatf("lru%0d_send", k), bus.flit_send, 1);
            tick();
            bus.credit_in = 1'b0;
            check($sformatf("lru%0d_bubble_busy", k), bus.busy, 0);
            check($sformatf("lru%0d_bubble_grt", k), bus.grt, 0);
        end
        clear_inputs();
        check("lru_cnt", bus.credit_cnt, CREDITS);
        check("lru_err", bus.credit_err, 0);

        // Multicast beats a higher-ranked unicast
        bus.u_req = 5'b00001;
        bus.m_req = 5'b00100;
        sb.push_back(2);
        expect_grant("mc");
        clear_inputs();
        bus.flit_vld  = 5'b00100;
        bus.flit_tail = 5'b00100;
        sample();
        check("mc_send", bus.flit_send, 1);
        tick();
        clear_inputs();
        check("mc_release", bus.busy, 0);

        // Masked multicast falls back to unicast
        bus.u_req     = 5'b00001;
        bus.m_req     = 5'b00100;
        bus.multab_ct = 5'b00100;
        sb.push_back(0);
        expect_grant("mc_masked");
        clear_inputs();
        bus.flit_vld  = 5'b00001;
        bus.flit_tail = 5'b00001;
        sample();
        check("mc_masked_send", bus.flit_send, 1);
        tick();
        clear_inputs();
        check("mc_masked_release", bus.busy, 0);
        check("mc_cnt", bus.credit_cnt, 2);
        bus.credit_in = 1'b1;
        tick();
        tick();
        bus.credit_in = 1'b0;
        check("refill_cnt", bus.credit_cnt, 4);

        // Wormhole hold: 4-flit packet from input 3 while input 4 waits
        bus.u_req = 5'b11000;
        sb.push_back(3);
        sb.push_back(4);
        expect_grant("worm_head");
        bus.u_req = 5'b10000;
        sends = 0;
        for (int k = 0; k < 5; k++) begin
            bus.flit_vld  = {1'b1, wv[k], 3'b000};
            bus.flit_tail = {1'b0, (k == 4), 3'b000};
            sample();
            check($sformatf("worm%0d_grt", k), bus.grt, 5'b01000);
            check($sformatf("worm%0d_send", k), bus.flit_send, wv[k]);
            if (bus.flit_send === 1'b1) sends++;
            tick();
        end
        check("worm_release_busy", bus.busy, 0);
        check("worm_release_grt", bus.grt, 0);
        check("worm_sends", sends, 4);
        check("worm_cnt", bus.credit_cnt, 0);
        expect_grant("worm_next");

        // Credit stall with input 4 as owner: refill, then a 6-flit packet
        clear_inputs();
        bus.credit_in = 1'b1;
        repeat (4) tick();
        bus.credit_in = 1'b0;
        check("stall_refill_cnt", bus.credit_cnt, 4);
        check("stall_hold_busy", bus.busy, 1);
        bus.flit_vld = 5'b10000;
        for (int k = 0; k < 4; k++) begin
            sample();
            check($sformatf("stall_send%0d", k), bus.flit_send, 1);
            tick();
        end
        check("stall_cnt_zero", bus.credit_cnt, 0);
        for (int k = 0; k < 2; k++) begin
            sample();
            check($sformatf("stall_blocked%0d", k), bus.flit_send, 0);
            tick();
        end
        check("stall_still_locked", bus.grt, 5'b10000);
        bus.credit_in = 1'b1;
        sample();
        check("stall_credit_cycle_send", bus.flit_send, 0);
        tick();
        bus.credit_in = 1'b0;
        check("stall_cnt_one", bus.credit_cnt, 1);
        sample();
        check("stall_one_send", bus.flit_send, 1);
        tick();
        check("stall_cnt_back_zero", bus.credit_cnt, 0);
        sample();
        check("stall_blocked_again", bus.flit_send, 0);
        bus.flit_tail = 5'b10000;
        bus.credit_in = 1'b1;
        tick();
        bus.credit_in = 1'b0;
        sample();
        check("stall_tail_send", bus.flit_send, 1);
        tick();
        clear_inputs();
        check("stall_release", bus.busy, 0);
        check("stall_final_cnt", bus.credit_cnt, 0);

        // Send and credit return in the same cycle leave the count alone
        bus.credit_in = 1'b1;
        tick();
        tick();
        bus.credit_in = 1'b0;
        check("simul_pre_cnt", bus.credit_cnt, 2);
        bus.u_req = 5'b00010;
        sb.push_back(1);
        expect_grant("simul");
        bus.u_req     = '0;
        bus.flit_vld  = 5'b00010;
        bus.credit_in = 1'b1;
        sample();
        check("simul_send", bus.flit_send, 1);
        tick();
        check("simul_cnt", bus.credit_cnt, 2);
        bus.credit_in = 1'b0;
        bus.flit_tail = 5'b00010;
        tick();
        clear_inputs();
        check("simul_release", bus.busy, 0);
        check("simul_post_cnt", bus.credit_cnt, 1);

        // Overflow: credit return while full
        bus.credit_in = 1'b1;
        repeat (3) tick();
        check("ovf_full_cnt", bus.credit_cnt, 4);
        check("ovf_err_clear", bus.credit_err, 0);
        tick();
        check("ovf_cnt_capped", bus.credit_cnt, 4);
        check("ovf_err_set", bus.credit_err, 1);
        bus.credit_in = 1'b0;
        tick();
        tick();
        check("ovf_err_sticky", bus.credit_err, 1);

        // Reset mid-packet with one credit left
        bus.u_req = 5'b00001;
        sb.push_back(0);
        expect_grant("rst_pre");
        bus.u_req    = '0;
        bus.flit_vld = 5'b00001;
        repeat (3) tick();
        bus.flit_vld = '0;
        check("rst_pre_cnt", bus.credit_cnt, 1);
        check("rst_pre_busy", bus.busy, 1);
        rst_ = 1'b0;
        tick();
        rst_ = 1'b1;
        check("rst_mid_grt", bus.grt, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_cnt", bus.credit_cnt, CREDITS);
        check("rst_mid_err", bus.credit_err, 0);
        check("rst_mid_sel", bus.sel, 0);
        bus.u_req     = '1;
        bus.flit_vld  = '1;
        bus.flit_tail = '1;
        sb.push_back(4);
        sb.push_back(3);
        expect_grant("rst_prio0");
        tick();
        check("rst_prio0_release", bus.busy, 0);
        expect_grant("rst_prio1");
        clear_inputs();
        tick();
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
